// File: rtl/mp3_pkg.sv
// Shared MP3 serial protocol definitions: frame marker bytes, reply CMD codes,
// parser/receiver state encodings and the frame checksum helper.
package mp3_pkg;

  localparam logic [7:0] SOF = 8'h7E;
  localparam logic [7:0] VER = 8'hFF;
  localparam logic [7:0] LEN = 8'h06;
  localparam logic [7:0] EOF = 8'hEF;

  localparam logic [7:0] CMD_TRACK_DONE = 8'h3D;
  localparam logic [7:0] CMD_INIT_DONE  = 8'h3F;
  localparam logic [7:0] CMD_ERROR      = 8'h40;
  localparam logic [7:0] CMD_ACK        = 8'h41;

  typedef enum logic [3:0] {
    ST_IDLE, ST_VER, ST_LEN, ST_CMD, ST_FB, ST_P1, ST_P2, ST_CKH, ST_CKL, ST_EOF
  } parse_state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic        fb;
    logic [15:0] param;
  } resp_t;

  // Sum of the checksummed frame bytes; VER and LEN are fixed once the header matched.
  function automatic logic [15:0] frame_sum(input logic [7:0] cmd, input logic [7:0] fb,
                                            input logic [7:0] p1, input logic [7:0] p2);
    return 16'(VER) + 16'(LEN) + 16'(cmd) + 16'(fb) + 16'(p1) + 16'(p2);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF rx synchroniser, mid-bit sampling baud counter, LSB-first shifter.
module uart_rx_byte
  import mp3_pkg::*;
#(
  parameter int unsigned BIT_CYC = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_stop_err,
  output logic       o_idle_c
);

  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC);

  logic [2:0]       r_sync;
  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic             w_rx, w_fall, w_tick, w_half;

  // [1:0] synchronise, [2] holds the previous synchronised level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], i_rx};
  end

  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];
  assign w_tick = (r_cnt == CNT_W'(BIT_CYC - 1));
  assign w_half = (r_cnt == CNT_W'(HALF_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: if (w_half) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_tick) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      RX_IDLE: w_cnt_nxt = '0;
      RX_START: begin
        if (w_half) begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_valid_nxt = w_rx;
          w_err_nxt   = ~w_rx;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_valid;
  assign o_stop_err   = r_err;
  assign o_idle_c     = (r_state == RX_IDLE);

endmodule

// File: rtl/mp3_resp_rx.sv
// MP3 module reply receiver: frames 7E FF 06 CMD FB P1 P2 CKH CKL EF, checks the checksum.
// Build option MP3_RX_TIMEOUT_EN adds an inter-byte idle timeout inside a frame.
module mp3_resp_rx
  import mp3_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        resp_valid,
  output logic [7:0]  resp_cmd,
  output logic        resp_fb,
  output logic [15:0] resp_param,
  output logic        err_chk,
  output logic        err_frame
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned TO_CYC  = TIMEOUT_BITS * BIT_CYC;

  logic [7:0]   w_byte;
  logic         w_byte_valid, w_stop_err, w_rx_idle, w_timeout;
  parse_state_e r_state, w_state_nxt, w_resync;
  logic [7:0]   r_cmd, r_fb, r_p1, r_p2, r_ckh, r_ckl;
  logic [15:0]  w_total;
  logic         w_valid_nxt, w_chk_nxt, w_frame_nxt;
  logic         r_valid, r_chk, r_frame;
  resp_t        r_resp;

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_stop_err   (w_stop_err),
    .o_idle_c     (w_rx_idle)
  );

`ifdef MP3_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Idle time inside a frame, only while the receiver is waiting for a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              r_to_cnt <= '0;
    else if (w_byte_valid || (r_state == ST_IDLE) || w_timeout) r_to_cnt <= '0;
    else if (w_rx_idle)                                      r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_timeout = (r_state != ST_IDLE) && w_rx_idle && !w_byte_valid && !w_stop_err &&
                     (r_to_cnt == TO_W'(TO_CYC - 1));
`else
  logic w_unused_to;
  assign w_unused_to = w_rx_idle ^ TO_CYC[0];
  assign w_timeout   = 1'b0;
`endif

  // A 7E that breaks a header/trailer check is taken as the start of a new frame
  assign w_resync = (w_byte == SOF) ? ST_VER : ST_IDLE;
  assign w_total  = frame_sum(r_cmd, r_fb, r_p1, r_p2) + {r_ckh, r_ckl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop_err || w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (w_byte_valid) begin
      case (r_state)
        ST_IDLE: if (w_byte == SOF) w_state_nxt = ST_VER;
        ST_VER:  w_state_nxt = (w_byte == VER) ? ST_LEN : w_resync;
        ST_LEN:  w_state_nxt = (w_byte == LEN) ? ST_CMD : w_resync;
        ST_CMD:  w_state_nxt = ST_FB;
        ST_FB:   w_state_nxt = ST_P1;
        ST_P1:   w_state_nxt = ST_P2;
        ST_P2:   w_state_nxt = ST_CKH;
        ST_CKH:  w_state_nxt = ST_CKL;
        ST_CKL:  w_state_nxt = ST_EOF;
        ST_EOF:  w_state_nxt = (w_byte == EOF) ? ST_IDLE : w_resync;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_valid_nxt = 1'b0;
    w_chk_nxt   = 1'b0;
    w_frame_nxt = w_stop_err | w_timeout;
    if (w_byte_valid) begin
      case (r_state)
        ST_VER: if (w_byte != VER) w_frame_nxt = 1'b1;
        ST_LEN: if (w_byte != LEN) w_frame_nxt = 1'b1;
        ST_EOF: begin
          if (w_byte != EOF)         w_frame_nxt = 1'b1;
          else if (w_total == 16'h0) w_valid_nxt = 1'b1;
          else                       w_chk_nxt   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_fb  <= '0;
      r_p1  <= '0;
      r_p2  <= '0;
      r_ckh <= '0;
      r_ckl <= '0;
    end else if (w_byte_valid) begin
      case (r_state)
        ST_CMD:  r_cmd <= w_byte;
        ST_FB:   r_fb  <= w_byte;
        ST_P1:   r_p1  <= w_byte;
        ST_P2:   r_p2  <= w_byte;
        ST_CKH:  r_ckh <= w_byte;
        ST_CKL:  r_ckl <= w_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_chk   <= 1'b0;
      r_frame <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_chk   <= w_chk_nxt;
      r_frame <= w_frame_nxt;
      if (w_valid_nxt) r_resp <= '{cmd: r_cmd, fb: r_fb[0], param: {r_p1, r_p2}};
    end
  end

  assign resp_valid = r_valid;
  assign err_chk    = r_chk;
  assign err_frame  = r_frame;
  assign resp_cmd   = r_resp.cmd;
  assign resp_fb    = r_resp.fb;
  assign resp_param = r_resp.param;

endmodule

// File: tb/tb_mp3_resp_rx.sv
// Bench for mp3_resp_rx at a scaled-down bit rate (16 clocks per bit); byte-level frame model.
module tb_mp3_resp_rx;

  localparam int unsigned CLK_HZ  = 160;
  localparam int unsigned BAUD    = 10;
  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned TO_BITS = 20;

  localparam logic [1:0] EV_GOOD  = 2'd1;
  localparam logic [1:0] EV_CHK   = 2'd2;
  localparam logic [1:0] EV_FRAME = 2'd3;

  typedef logic [26:0] evt_t;      // {kind, fb, cmd, param}
  typedef logic [7:0]  frame_t [10];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        resp_valid, resp_fb, err_chk, err_frame;
  logic [7:0]  resp_cmd;
  logic [15:0] resp_param;

  int errors = 0;
  int checks = 0;

  evt_t       obs_q[$];
  evt_t       exp_q[$];
  logic [7:0] buf_q[$];
  logic [7:0] m_cmd = 8'h00;
  logic       m_fb = 1'b0;
  logic [15:0] m_param = 16'h0000;

  mp3_resp_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .resp_valid (resp_valid),
    .resp_cmd   (resp_cmd),
    .resp_fb    (resp_fb),
    .resp_param (resp_param),
    .err_chk    (err_chk),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  // Record every output pulse; pulses must be mutually exclusive
  always @(negedge clk) begin
    if (rst_n && (resp_valid || err_chk || err_frame)) begin
      checks++;
      if ($countones({resp_valid, err_chk, err_frame}) != 1) begin
        errors++;
        $display("FAIL pulse_overlap: got valid/chk/frame=%b%b%b want one-hot", resp_valid, err_chk, err_frame);
      end
      if (resp_valid) obs_q.push_back({EV_GOOD, resp_fb, resp_cmd, resp_param});
      if (err_chk)    obs_q.push_back({EV_CHK, 25'd0});
      if (err_frame)  obs_q.push_back({EV_FRAME, 25'd0});
    end
  end

  // Reference model: partial frame kept as a byte list, judged by position
  function automatic void model_byte(input logic [7:0] b);
    int pos;
    int s;
    if (buf_q.size() == 0) begin
      if (b == 8'h7E) buf_q.push_back(b);
      return;
    end
    pos = buf_q.size();
    if ((pos == 1 && b != 8'hFF) || (pos == 2 && b != 8'h06) || (pos == 9 && b != 8'hEF)) begin
      exp_q.push_back({EV_FRAME, 25'd0});
      buf_q.delete();
      if (b == 8'h7E) buf_q.push_back(b);
      return;
    end
    buf_q.push_back(b);
    if (buf_q.size() == 10) begin
      s = 0;
      for (int i = 1; i <= 6; i++) s += int'(buf_q[i]);
      s += int'(buf_q[7]) * 256 + int'(buf_q[8]);
      if (s % 65536 == 0) begin
        m_cmd   = buf_q[3];
        m_fb    = buf_q[4][0];
        m_param = {buf_q[5], buf_q[6]};
        exp_q.push_back({EV_GOOD, m_fb, m_cmd, m_param});
      end else begin
        exp_q.push_back({EV_CHK, 25'd0});
      end
      buf_q.delete();
    end
  endfunction

  function automatic void model_break();
    exp_q.push_back({EV_FRAME, 25'd0});
    buf_q.delete();
  endfunction

  function automatic logic [15:0] ck16(input logic [7:0] c, input logic [7:0] fb,
                                       input logic [7:0] p1, input logic [7:0] p2);
    int s;
    s = 255 + 6 + int'(c) + int'(fb) + int'(p1) + int'(p2);
    return 16'((65536 - s) % 65536);
  endfunction

  // Compares and drains the observed/expected event lists; "" when they agree
  function automatic string take_evt_diff();
    string s;
    s = "";
    if (obs_q.size() != exp_q.size())
      s = $sformatf("got %0d events want %0d", obs_q.size(), exp_q.size());
    else
      foreach (obs_q[i])
        if (s == "" && obs_q[i] !== exp_q[i])
          s = $sformatf("event %0d got %h want %h", i, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    return s;
  endfunction

  task automatic gap(input int unsigned bits);
    rx = 1'b1;
    repeat (bits * BIT_CYC) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
    if (stop_ok) model_byte(b);
    else         model_break();
  endtask

  task automatic send_frame(input frame_t f, input int unsigned max_gap);
    for (int i = 0; i < 10; i++) begin
      send_byte(f[i], 1'b1);
      gap($urandom_range(0, max_gap));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, err_chk, err_frame} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 000", {resp_valid, err_chk, err_frame});
    end
    checks++;
    if ({resp_cmd, resp_fb, resp_param} !== 25'd0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0", {resp_cmd, resp_fb, resp_param});
    end
    rst_n = 1'b1;
    gap(2);
  endtask

  task automatic test_good_frame();
    frame_t f;
    string  d;
    f = '{8'h7E, 8'hFF, 8'h06, 8'h3D, 8'h00, 8'h00, 8'h05, 8'hFE, 8'hB9, 8'hEF};
    send_frame(f, 0);
    gap(4);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL good_count: got %0d pulses want 1", obs_q.size());
    end
    checks++;
    if ({resp_cmd, resp_fb, resp_param} !== {8'h3D, 1'b0, 16'h0005}) begin
      errors++;
      $display("FAIL good_resp: got %h/%b/%h want 3d/0/0005", resp_cmd, resp_fb, resp_param);
    end
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL good_events: %s", d); end
  endtask

  task automatic test_bad_checksum();
    frame_t f;
    string  d;
    f = '{8'h7E, 8'hFF, 8'h06, 8'h3D, 8'h00, 8'h00, 8'h05, 8'hFE, 8'hBA, 8'hEF};
    send_frame(f, 0);
    gap(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0][26:25] !== EV_CHK) begin
      errors++;
      $display("FAIL chk_pulse: got %0d pulses want one err_chk", obs_q.size());
    end
    checks++;
    if ({resp_cmd, resp_param} !== {8'h3D, 16'h0005}) begin
      errors++;
      $display("FAIL chk_hold: got %h/%h want 3d/0005", resp_cmd, resp_param);
    end
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL chk_events: %s", d); end
  endtask

  task automatic test_bad_len();
    frame_t     f;
    logic [15:0] ck;
    string      d;
    send_byte(8'h7E, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h07, 1'b1);
    gap(2);
    ck = ck16(8'h3F, 8'h01, 8'h12, 8'h34);
    f = '{8'h7E, 8'hFF, 8'h06, 8'h3F, 8'h01, 8'h12, 8'h34, ck[15:8], ck[7:0], 8'hEF};
    send_frame(f, 1);
    gap(4);
    checks++;
    if ({resp_cmd, resp_fb, resp_param} !== {8'h3F, 1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL len_resp: got %h/%b/%h want 3f/1/1234", resp_cmd, resp_fb, resp_param);
    end
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL len_events: %s", d); end
  endtask

  task automatic test_resync();
    frame_t f;
    string  d;
    send_byte(8'h7E, 1'b1);
    f = '{8'h7E, 8'hFF, 8'h06, 8'h41, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hBA, 8'hEF};
    send_frame(f, 0);
    gap(4);
    checks++;
    if (obs_q.size() != 2 || obs_q[0][26:25] !== EV_FRAME) begin
      errors++;
      $display("FAIL resync_seq: got %0d pulses want err_frame then resp_valid", obs_q.size());
    end
    checks++;
    if ({resp_cmd, resp_param} !== {8'h41, 16'h0000}) begin
      errors++;
      $display("FAIL resync_resp: got %h/%h want 41/0000", resp_cmd, resp_param);
    end
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL resync_events: %s", d); end
  endtask

  task automatic test_stop_and_glitch();
    string d;
    send_byte(8'h7E, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h06, 1'b0);
    gap(3);
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL stop_events: %s", d); end
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    gap(4);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_quiet: got %0d pulses want 0", obs_q.size());
    end
    void'(take_evt_diff());
  endtask

  task automatic test_random();
    frame_t      f;
    logic [7:0]  c, fb, p1, p2;
    logic [15:0] ck;
    int          kind, pos;
    string       d;
    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 3);
      c  = 8'($urandom);
      fb = 8'($urandom);
      p1 = 8'($urandom);
      p2 = 8'($urandom);
      ck = ck16(c, fb, p1, p2);
      f = '{8'h7E, 8'hFF, 8'h06, c, fb, p1, p2, ck[15:8], ck[7:0], 8'hEF};
      if (kind == 1) f[8] = f[8] ^ 8'($urandom_range(1, 255));
      if (kind == 2) begin
        pos = $urandom_range(0, 2);
        pos = (pos == 0) ? 1 : (pos == 1) ? 2 : 9;
        f[pos] = f[pos] ^ 8'($urandom_range(1, 255));
      end
      if (kind == 3) repeat ($urandom_range(1, 3)) send_byte(8'($urandom), 1'b1);
      send_frame(f, 1);
    end
    send_byte(8'h55, 1'b0);
    gap(4);
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL random_events: %s", d); end
    checks++;
    if ({resp_cmd, resp_fb, resp_param} !== {m_cmd, m_fb, m_param}) begin
      errors++;
      $display("FAIL random_resp: got %h/%b/%h want %h/%b/%h", resp_cmd, resp_fb, resp_param, m_cmd, m_fb, m_param);
    end
  endtask

  task automatic test_timeout();
    frame_t      f;
    logic [15:0] ck;
    int          n_err;
    string       d;
    send_byte(8'h7E, 1'b1);
    send_byte(8'hFF, 1'b1);
    gap(25);
`ifdef MP3_RX_TIMEOUT_EN
    model_break();
    n_err = 1;
`else
    n_err = 0;
`endif
    checks++;
    if (obs_q.size() != n_err) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses want %0d", obs_q.size(), n_err);
    end
    ck = ck16(8'h40, 8'h00, 8'hA5, 8'h5A);
    f = '{8'h7E, 8'hFF, 8'h06, 8'h40, 8'h00, 8'hA5, 8'h5A, ck[15:8], ck[7:0], 8'hEF};
    send_frame(f, 0);
    gap(4);
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL timeout_events: %s", d); end
  endtask

  task automatic test_reset_mid();
    frame_t      f;
    logic [15:0] ck;
    string       d;
    send_byte(8'h7E, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h06, 1'b1);
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL prereset_events: %s", d); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, err_chk, err_frame, resp_cmd, resp_fb, resp_param} !== 28'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0", {resp_valid, err_chk, err_frame, resp_cmd, resp_fb, resp_param});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    buf_q.delete();
    m_cmd = 8'h00;
    m_fb = 1'b0;
    m_param = 16'h0000;
    obs_q.delete();
    exp_q.delete();
    gap(1);
    ck = ck16(8'h3D, 8'h01, 8'h00, 8'h07);
    f = '{8'h7E, 8'hFF, 8'h06, 8'h3D, 8'h01, 8'h00, 8'h07, ck[15:8], ck[7:0], 8'hEF};
    send_frame(f, 0);
    gap(4);
    checks++;
    if ({resp_cmd, resp_fb, resp_param} !== {8'h3D, 1'b1, 16'h0007}) begin
      errors++;
      $display("FAIL postreset_resp: got %h/%b/%h want 3d/1/0007", resp_cmd, resp_fb, resp_param);
    end
    d = take_evt_diff();
    checks++;
    if (d != "") begin errors++; $display("FAIL postreset_events: %s", d); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_len();
    test_resync();
    test_stop_and_glitch();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
